// File: rtl/padding_row_ctrl.sv
// -----------------------------------------------------------------------------
// padding_row_ctrl
//
// Sequencing controller for the zero-padding stage in front of the first 3x3
// convolution layer. It fetches image rows beat by beat and writes them into
// three rotating line buffers. It inserts an all-zero top row and an all-zero
// bottom row without consuming input. Each time a 3-row window is complete, it
// hands the window to the convolution engine through a valid/ack handshake.
//
// Padded row p (0..IMG_H+1) lives in buffer p mod 3. Rows p=0 and p=IMG_H+1
// are the zero rows. Output row r uses padded rows r..r+2, so its top row is
// in buffer r mod 3.
//
// Ports:
//   clk, reset     clock; asynchronous active-high reset
//   start          one-cycle pulse, begins a frame when idle
//   in_valid       upstream beat available
//   in_ready       controller accepts a beat this cycle (LOAD only)
//   wr_en          line-buffer write strobe
//   wr_zero        write zeros instead of input data
//   wr_buf         physical buffer 0..2 being written
//   wr_col         beat index 0..BEATS-1 within the row
//   win_valid      3-row window ready (registered)
//   win_top        buffer holding the window's top row
//   win_row        output row index 0..IMG_H-1
//   win_ack        consumer finished with the window
//   busy           frame in progress
//   done           one-cycle pulse after the last window is acked
//   stall_cnt      cycles spent in LOAD with in_valid low
//
// Build option: define PADDING_ROW_CTRL_STATS_EN to include the saturating
// stall counter. Without it, stall_cnt is tied to zero.
// -----------------------------------------------------------------------------
module padding_row_ctrl #(
    parameter int IMG_H = 416,
    parameter int BEATS = 52,
    parameter int COL_W = 6,
    parameter int ROW_W = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             wr_en,
    output logic             wr_zero,
    output logic [1:0]       wr_buf,
    output logic [COL_W-1:0] wr_col,
    output logic             win_valid,
    output logic [1:0]       win_top,
    output logic [ROW_W-1:0] win_row,
    input  logic             win_ack,
    output logic             busy,
    output logic             done,
    output logic [15:0]      stall_cnt
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ZERO = 3'd1;
    localparam logic [2:0] S_LOAD = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(BEATS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);
    localparam logic [ROW_W-1:0] BOT_PAD  = ROW_W'(IMG_H + 1);

    logic [2:0]       state;
    logic [ROW_W-1:0] pad_row;   // padded row currently being written
    logic [ROW_W-1:0] out_row;   // output row offered / next to offer
    logic [COL_W-1:0] col;
    logic [1:0]       pad_buf;   // pad_row mod 3, tracked incrementally
    logic [1:0]       top_buf;   // out_row mod 3, tracked incrementally

    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    // All outputs decode from registered state, so win_valid is a flop
    // output. wr_en in LOAD follows in_valid combinationally, and that is what
    // lets the controller accept a beat every cycle.
    assign in_ready  = (state == S_LOAD);
    assign wr_zero   = (state == S_ZERO);
    assign wr_en     = wr_zero || (in_ready && in_valid);
    assign wr_buf    = pad_buf;
    assign wr_col    = col;
    assign win_valid = (state == S_WAIT);
    assign win_top   = top_buf;
    assign win_row   = out_row;
    assign busy      = (state == S_ZERO) || (state == S_LOAD) || (state == S_WAIT);
    assign done      = (state == S_DONE);

    // NOTE: sequential state uses non-blocking assignments only. Every flop
    //       here, including the row/column bookkeeping, is cleared by the
    //       asynchronous reset, so an aborted frame leaves nothing behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            pad_row <= '0;
            out_row <= '0;
            col     <= '0;
            pad_buf <= '0;
            top_buf <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_ZERO;
                        pad_row <= '0;
                        out_row <= '0;
                        col     <= '0;
                        pad_buf <= '0;
                        top_buf <= '0;
                    end
                end
                S_ZERO, S_LOAD: begin
                    if (wr_en) begin
                        if (col == LAST_COL) begin
                            col     <= '0;
                            pad_row <= pad_row + ROW_W'(1);
                            pad_buf <= inc3(pad_buf);
                            // Rows 0..2 are needed before the first window exists.
                            state   <= (pad_row < ROW_W'(2)) ? S_LOAD : S_WAIT;
                        end else begin
                            col <= col + COL_W'(1);
                        end
                    end
                end
                S_WAIT: begin
                    if (win_ack) begin
                        out_row <= out_row + ROW_W'(1);
                        top_buf <= inc3(top_buf);
                        // The next padded row to write is out_row+3. It reuses the
                        // buffer that was just released.
                        if (out_row == LAST_ROW)
                            state <= S_DONE;
                        else if (out_row + ROW_W'(3) == BOT_PAD)
                            state <= S_ZERO;
                        else
                            state <= S_LOAD;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef PADDING_ROW_CTRL_STATS_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_q <= '0;
        else if (state == S_IDLE && start)
            stall_q <= '0;
        else if (state == S_LOAD && !in_valid && stall_q != 16'hFFFF)
            stall_q <= stall_q + 16'd1;
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_padding_row_ctrl.sv
// -----------------------------------------------------------------------------
// tb_padding_row_ctrl
//
// Two instances run side by side. One is a small frame (IMG_H=4, BEATS=2) used
// for the directed scenarios. The other uses the default size for the
// full-frame latency and count run. A per-instance event queue is built from
// the padding rules: the writes of each padded row, each window, and the final
// done. It is compared against the DUT outputs on every falling edge. Literal
// expectations pin the small-frame write order and the frame timing.
// -----------------------------------------------------------------------------
module tb_padding_row_ctrl;

    localparam int SH = 4,   SB = 2,  SCW = 1, SRW = 3;
    localparam int DH = 416, DB = 52, DCW = 6, DRW = 9;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // small instance
    logic           reset_s, start_s, in_valid_s, win_ack_s;
    logic           in_ready_s, wr_en_s, wr_zero_s, win_valid_s, busy_s, done_s;
    logic [1:0]     wr_buf_s, win_top_s;
    logic [SCW-1:0] wr_col_s;
    logic [SRW-1:0] win_row_s;
    logic [15:0]    stall_cnt_s;

    // default-size instance
    logic           reset_d, start_d, in_valid_d, win_ack_d;
    logic           in_ready_d, wr_en_d, wr_zero_d, win_valid_d, busy_d, done_d;
    logic [1:0]     wr_buf_d, win_top_d;
    logic [DCW-1:0] wr_col_d;
    logic [DRW-1:0] win_row_d;
    logic [15:0]    stall_cnt_d;

    padding_row_ctrl #(.IMG_H(SH), .BEATS(SB), .COL_W(SCW), .ROW_W(SRW)) dut_s (
        .clk(clk), .reset(reset_s), .start(start_s), .in_valid(in_valid_s),
        .in_ready(in_ready_s), .wr_en(wr_en_s), .wr_zero(wr_zero_s),
        .wr_buf(wr_buf_s), .wr_col(wr_col_s), .win_valid(win_valid_s),
        .win_top(win_top_s), .win_row(win_row_s), .win_ack(win_ack_s),
        .busy(busy_s), .done(done_s), .stall_cnt(stall_cnt_s)
    );

    padding_row_ctrl #(.IMG_H(DH), .BEATS(DB), .COL_W(DCW), .ROW_W(DRW)) dut_d (
        .clk(clk), .reset(reset_d), .start(start_d), .in_valid(in_valid_d),
        .in_ready(in_ready_d), .wr_en(wr_en_d), .wr_zero(wr_zero_d),
        .wr_buf(wr_buf_d), .wr_col(wr_col_d), .win_valid(win_valid_d),
        .win_top(win_top_d), .win_row(win_row_d), .win_ack(win_ack_d),
        .busy(busy_d), .done(done_d), .stall_cnt(stall_cnt_d)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {EV_WR, EV_WIN, EV_DONE} ev_kind_e;
    typedef struct {
        ev_kind_e kind;
        int       zero;
        int       bufn;
        int       col;
        int       row;
        int       top;
    } ev_t;

    ev_t mq[2][$];
    int  mstall[2];

    task automatic push_row(int idx, int p, int h, int b);
        for (int c = 0; c < b; c++) begin
            ev_t e;
            e.kind = EV_WR; e.zero = (p == 0 || p == h + 1) ? 1 : 0;
            e.bufn = p % 3; e.col = c; e.row = 0; e.top = 0;
            mq[idx].push_back(e);
        end
    endtask

    task automatic build_frame(int idx, int h, int b);
        ev_t e;
        mq[idx].delete();
        mstall[idx] = 0;
        for (int p = 0; p < 3; p++) push_row(idx, p, h, b);
        for (int r = 0; r < h; r++) begin
            e.kind = EV_WIN; e.zero = 0; e.bufn = 0; e.col = 0; e.row = r; e.top = r % 3;
            mq[idx].push_back(e);
            if (r == h - 1) begin
                e.kind = EV_DONE;
                mq[idx].push_back(e);
            end else begin
                push_row(idx, r + 3, h, b);
            end
        end
    endtask

    task automatic model_cycle(int idx, int iv, int ack, int ir, int we, int wz, int wb,
                               int wc, int wv, int wt, int wrow, int bz, int dn, int st);
        ev_t   e;
        bit    have = (mq[idx].size() > 0);
        string px   = (idx == 0) ? "s" : "d";
        int    e_ir, e_we, e_wv, e_dn, e_bz;
        if (have) e = mq[idx][0];
        e_ir = (have && e.kind == EV_WR && e.zero == 0) ? 1 : 0;
        e_we = (have && e.kind == EV_WR && (e.zero == 1 || iv != 0)) ? 1 : 0;
        e_wv = (have && e.kind == EV_WIN) ? 1 : 0;
        e_dn = (have && e.kind == EV_DONE) ? 1 : 0;
        e_bz = (have && e.kind != EV_DONE) ? 1 : 0;
        check({px, ".in_ready"}, ir, e_ir);
        check({px, ".wr_en"}, we, e_we);
        check({px, ".win_valid"}, wv, e_wv);
        check({px, ".done"}, dn, e_dn);
        check({px, ".busy"}, bz, e_bz);
`ifdef PADDING_ROW_CTRL_STATS_EN
        check({px, ".stall_cnt"}, st, mstall[idx]);
`else
        check({px, ".stall_cnt"}, st, 0);
`endif
        if (e_we == 1) begin
            check({px, ".wr_zero"}, wz, e.zero);
            check({px, ".wr_buf"}, wb, e.bufn);
            check({px, ".wr_col"}, wc, e.col);
            void'(mq[idx].pop_front());
        end
        if (e_wv == 1) begin
            check({px, ".win_row"}, wrow, e.row);
            check({px, ".win_top"}, wt, e.top);
            if (ack != 0) void'(mq[idx].pop_front());
        end
        if (e_dn == 1) void'(mq[idx].pop_front());
        if (e_ir == 1 && iv == 0 && mstall[idx] < 65535) mstall[idx]++;
    endtask

    always @(negedge clk) if (!reset_s)
        model_cycle(0, in_valid_s, win_ack_s, in_ready_s, wr_en_s, wr_zero_s, wr_buf_s,
                    wr_col_s, win_valid_s, win_top_s, win_row_s, busy_s, done_s, stall_cnt_s);
    always @(negedge clk) if (!reset_d)
        model_cycle(1, in_valid_d, win_ack_d, in_ready_d, wr_en_d, wr_zero_d, wr_buf_d,
                    wr_col_d, win_valid_d, win_top_d, win_row_d, busy_d, done_d, stall_cnt_d);

    // ---------------- frame monitor ----------------
    int fcyc[2], first_win[2], done_cyc[2], win_cnt[2], n_done[2];
    bit counting[2], done_seen[2], prev_wv[2];
    int wlog[$];   // small instance: zero*4 + buf per write
    int tlog[$];   // small instance: win_top per window

    task automatic mon(int idx, int wv, int ack, int dn, int we, int wz, int wb, int wt);
        if (!counting[idx]) begin
            prev_wv[idx] = (wv != 0);
            return;
        end
        fcyc[idx]++;
        if (idx == 0 && we != 0) wlog.push_back(wz * 4 + wb);
        if (wv != 0 && !prev_wv[idx]) begin
            if (first_win[idx] < 0) first_win[idx] = fcyc[idx];
            if (idx == 0) tlog.push_back(wt);
        end
        if (wv != 0 && ack != 0) win_cnt[idx]++;
        if (dn != 0) begin
            done_cyc[idx]  = fcyc[idx];
            n_done[idx]++;
            counting[idx]  = 1'b0;
            done_seen[idx] = 1'b1;
        end
        prev_wv[idx] = (wv != 0);
    endtask

    always @(negedge clk) if (!reset_s)
        mon(0, win_valid_s, win_ack_s, done_s, wr_en_s, wr_zero_s, wr_buf_s, win_top_s);
    always @(negedge clk) if (!reset_d)
        mon(1, win_valid_d, win_ack_d, done_d, wr_en_d, wr_zero_d, wr_buf_d, win_top_d);

    // ---------------- reactive drivers (ack / in_valid) ----------------
    int age[2], max_age[2], hold_row[2], hold_len[2];
    bit tog[2];

    always @(posedge clk) begin
        #1;
        if (win_valid_s) age[0]++; else age[0] = 0;
        if (age[0] > max_age[0]) max_age[0] = age[0];
        win_ack_s  = win_valid_s && (age[0] > ((int'(win_row_s) == hold_row[0]) ? hold_len[0] : 0));
        in_valid_s = tog[0] ? !in_valid_s : 1'b1;
    end

    always @(posedge clk) begin
        #1;
        if (win_valid_d) age[1]++; else age[1] = 0;
        win_ack_d  = win_valid_d && (age[1] > 0);
        in_valid_d = 1'b1;
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_start(int idx, bit accept);
        @(negedge clk);
        if (idx == 0) start_s = 1'b1; else start_d = 1'b1;
        @(posedge clk);
        #1;
        if (idx == 0) start_s = 1'b0; else start_d = 1'b0;
        if (accept) begin
            if (idx == 0) build_frame(0, SH, SB); else build_frame(1, DH, DB);
            fcyc[idx] = 0; first_win[idx] = -1; done_cyc[idx] = -1;
            win_cnt[idx] = 0; counting[idx] = 1'b1; done_seen[idx] = 1'b0;
            max_age[idx] = 0;
            if (idx == 0) begin wlog.delete(); tlog.delete(); end
        end
    endtask

    task automatic wait_done(int idx, int budget);
        int k = 0;
        while (!done_seen[idx] && k < budget) begin
            @(negedge clk);
            k++;
        end
        check((idx == 0) ? "s.done_timeout" : "d.done_timeout", done_seen[idx], 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_vals();
        check("rst.in_ready", in_ready_s, 0);
        check("rst.wr_en", wr_en_s, 0);
        check("rst.wr_zero", wr_zero_s, 0);
        check("rst.wr_buf", wr_buf_s, 0);
        check("rst.wr_col", wr_col_s, 0);
        check("rst.win_valid", win_valid_s, 0);
        check("rst.win_top", win_top_s, 0);
        check("rst.win_row", win_row_s, 0);
        check("rst.busy", busy_s, 0);
        check("rst.done", done_s, 0);
        check("rst.stall_cnt", stall_cnt_s, 0);
    endtask

    // Literal write order and window tops for the small frame.
    task automatic check_small_literal(string tag);
        int exp_w[12] = '{4, 4, 1, 1, 2, 2, 0, 0, 1, 1, 6, 6};
        int exp_t[4]  = '{0, 1, 2, 0};
        check({tag, ".n_writes"}, wlog.size(), 12);
        check({tag, ".n_windows"}, tlog.size(), 4);
        for (int i = 0; i < 12; i++)
            check($sformatf("%s.write%0d", tag, i), (i < wlog.size()) ? wlog[i] : -1, exp_w[i]);
        for (int i = 0; i < 4; i++)
            check($sformatf("%s.top%0d", tag, i), (i < tlog.size()) ? tlog[i] : -1, exp_t[i]);
        check({tag, ".first_win"}, first_win[0], 7);
        check({tag, ".done_cyc"}, done_cyc[0], 17);
    endtask

    task automatic small_seq();
        int k;
        // reset values
        check_reset_vals();
        @(negedge clk); #1 reset_s = 1'b0;
        repeat (2) @(negedge clk);

        // 1: nominal frame
        do_start(0, 1'b1);
        wait_done(0, 200);
        check_small_literal("f1");
        check("f1.n_done", n_done[0], 1);

        // 2: consumer holds window 1 for 20 cycles
        hold_row[0] = 1; hold_len[0] = 20;
        do_start(0, 1'b1);
        wait_done(0, 300);
        hold_row[0] = -1;
        check("f2.max_age", max_age[0], 21);
        check("f2.done_cyc", done_cyc[0], 37);

        // 3: in_valid alternating
        tog[0] = 1'b1;
        do_start(0, 1'b1);
        wait_done(0, 300);
        tog[0] = 1'b0;
        check("f3.n_writes", wlog.size(), 12);

        // 4: start pulses while busy are ignored
        do_start(0, 1'b1);
        repeat (3) @(negedge clk);
        do_start(0, 1'b0);
        repeat (5) @(negedge clk);
        do_start(0, 1'b0);
        wait_done(0, 200);
        check("f4.done_cyc", done_cyc[0], 17);
        check("f4.n_done", n_done[0], 4);

        // 5: reset during the load of padded row 2, then a clean frame
        do_start(0, 1'b1);
        k = 0;
        while (!(wr_buf_s == 2'd2 && in_ready_s) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("f5.reached_row2", (k < 100) ? 1 : 0, 1);
        #2 reset_s = 1'b1;
        mq[0].delete(); mstall[0] = 0; counting[0] = 1'b0;
        #1 check_reset_vals();
        @(negedge clk); #1 reset_s = 1'b0;
        repeat (2) @(negedge clk);
        do_start(0, 1'b1);
        wait_done(0, 200);
        check_small_literal("f6");
    endtask

    task automatic dflt_seq();
        @(negedge clk); #1 reset_d = 1'b0;
        repeat (2) @(negedge clk);
        do_start(1, 1'b1);
        wait_done(1, 30000);
        check("d.first_win", first_win[1], 157);
        check("d.windows", win_cnt[1], 416);
        check("d.done_cyc", done_cyc[1], 22153);
        check("d.n_done", n_done[1], 1);
        check("d.model_drained", mq[1].size(), 0);
    endtask

    initial begin
        reset_s = 1'b1; reset_d = 1'b1;
        start_s = 1'b0; start_d = 1'b0;
        in_valid_s = 1'b0; in_valid_d = 1'b0;
        win_ack_s = 1'b0; win_ack_d = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mstall[i] = 0; fcyc[i] = 0; first_win[i] = -1; done_cyc[i] = -1;
            win_cnt[i] = 0; n_done[i] = 0; counting[i] = 1'b0; done_seen[i] = 1'b0;
            prev_wv[i] = 1'b0; age[i] = 0; max_age[i] = 0; hold_row[i] = -1;
            hold_len[i] = 0; tog[i] = 1'b0;
        end
        #1;
        fork
            small_seq();
            dflt_seq();
        join
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
